coin_credit_accumulator: RTL
============================

# coin_credit_accumulator

Upstream front end of the vending machine controller. Accumulates coin credit from nickel, dime and quarter pulses and compares it against a fixed price. On a valid selection it issues a held vend request to the downstream dispense FSM, then returns any remaining credit as a train of one-nickel change pulses.

## Interface
- PRICE, 75: item price in cents; must be a non-zero multiple of 5 and ≤ MAX_CREDIT.
- MAX_CREDIT, 200: highest credit allowed in cents; must be a multiple of 5 and < 2^CREDIT_W.
- CREDIT_W, 8: width of the credit register and of o_CREDIT.
- i_CLK  in  1  system clock; all state changes on the rising edge.
- i_RESET  in  1  reset, **asynchronous, active-high**.
- i_NICKEL  in  1  single-cycle pulse: 5-cent coin inserted.
- i_DIME  in  1  single-cycle pulse: 10-cent coin inserted.
- i_QUARTER  in  1  single-cycle pulse: 25-cent coin inserted.
- i_SELECT  in  1  single-cycle pulse: item button pressed.
- i_CANCEL  in  1  single-cycle pulse: coin-return button pressed.
- i_VEND_DONE  in  1  single-cycle pulse from the downstream FSM: item dispensed.
- o_CREDIT  out  CREDIT_W  current credit in cents (registered).
- o_ENOUGH  out  1  high when o_CREDIT ≥ PRICE and state is COLLECT.
- o_VEND_REQ  out  1  high for the whole of state VEND_WAIT.
- o_CHANGE_NICKEL  out  1  high in CHANGE; each high cycle returns one nickel.
- o_COIN_REJECT  out  1  registered single-cycle pulse: the coin was not credited.
- o_BUSY  out  1  high in VEND_WAIT or CHANGE.

## Operation
- Inputs are synchronous to i_CLK.
- States: IDLE (credit 0), COLLECT (credit > 0), VEND_WAIT, CHANGE. Encode them as an enumerated state register.
- **Coin acceptance**:
  - Coins are credited only in IDLE or COLLECT.
  - The coin value is added to the credit.
  - IDLE moves to COLLECT.
- **Coin rejection**: o_COIN_REJECT pulses and the credit is unchanged when any of these holds:
  - more than one coin input is high in the same cycle;
  - the new sum would exceed MAX_CREDIT;
  - the state is VEND_WAIT or CHANGE;
  - i_SELECT or i_CANCEL is high in the same cycle.
- **Select**:
  - In COLLECT with credit ≥ PRICE, deduct PRICE from the credit and go to VEND_WAIT.
  - With insufficient credit, or in any other state, select is ignored with no response.
- **Cancel**:
  - In COLLECT, go to CHANGE, keeping the full credit.
  - In every other state, cancel is ignored.
  - If select and cancel are high in the same cycle, cancel wins.
- **VEND_WAIT**:
  - o_VEND_REQ is held high until i_VEND_DONE arrives.
  - On i_VEND_DONE, go to CHANGE if credit > 0, otherwise to IDLE.
  - i_VEND_DONE in any other state is ignored.
  - Coins, select and cancel are not accepted in this state.
- **CHANGE**:
  - o_CHANGE_NICKEL is high every cycle.
  - The credit decrements by 5 on each edge.
  - On the edge where the credit goes from 5 to 0, go to IDLE.
  - A credit of N·5 produces exactly N high cycles.
- Credit is always a multiple of 5, never exceeds MAX_CREDIT, and never wraps below 0.

## Timing
- **Reset**: o_CREDIT=0, state IDLE, and o_ENOUGH, o_VEND_REQ, o_CHANGE_NICKEL, o_COIN_REJECT, o_BUSY all 0. Outputs take these values immediately on assertion, with no clock edge.
- **Reset during operation**: reset in VEND_WAIT or CHANGE discards the credit with no change pulses, and o_VEND_REQ drops immediately.
- **Coin latency**: a coin pulse sampled at edge k updates o_CREDIT after edge k. A rejected coin sampled at edge k gives o_COIN_REJECT high for the single cycle after edge k.
- **Select latency**: a valid select sampled at edge k gives o_VEND_REQ high and o_CREDIT = credit − PRICE after edge k.
- **Handshake**: i_VEND_DONE sampled at edge m drops o_VEND_REQ after edge m. The first change cycle, if any, starts at the same moment.
- **Cancel latency**: a cancel sampled at edge k gives o_CHANGE_NICKEL high from edge k until the edge on which the credit reaches 0.
- **Derived outputs**: o_ENOUGH, o_VEND_REQ, o_CHANGE_NICKEL and o_BUSY are decoded from the state register and the credit register only. They are glitch-free, with no combinational path from any input.

## Test plan
Parameters for all scenarios: PRICE=75, MAX_CREDIT=200.
- **Exact price**: reset; quarter ×3 on separate cycles → o_CREDIT 25/50/75, o_ENOUGH=1 after the third; select → o_VEND_REQ=1, o_CREDIT=0; hold i_VEND_DONE low 5 cycles → o_VEND_REQ stays 1; pulse i_VEND_DONE → IDLE, no change pulses.
- **Overpay and change**: quarter ×3 plus dime → 85; select → credit 10; i_VEND_DONE → exactly 2 o_CHANGE_NICKEL cycles, then o_CREDIT=0, IDLE.
- **Rejects**:
  - nickel and dime in the same cycle → o_COIN_REJECT one cycle, credit unchanged;
  - quarter ×8 → 200, then a ninth quarter → rejected;
  - coin during VEND_WAIT → rejected.
- **Select and cancel**: credit 50 + select → ignored, o_VEND_REQ=0; cancel → 10 nickel cycles, then IDLE; select + cancel in the same cycle with credit 100 → CHANGE, 20 nickel cycles, no o_VEND_REQ.
- **Reset during operation**:
  - async reset asserted mid-CHANGE (between edges) → o_CHANGE_NICKEL and o_CREDIT go to 0 without a clock;
  - reset in VEND_WAIT → o_VEND_REQ=0 immediately;
  - i_VEND_DONE pulsed in IDLE → no effect.

Source files
------------

// File: rtl/coin_credit_accumulator.sv
// coin_credit_accumulator: coin credit front end of the vending controller
// Ports:
//   i_CLK, i_RESET (async, active-high)
//   i_NICKEL, i_DIME, i_QUARTER  coin pulses (5/10/25 cents)
//   i_SELECT, i_CANCEL           button pulses
//   i_VEND_DONE                  dispense-complete pulse from downstream FSM
//   o_CREDIT                     current credit in cents
//   o_ENOUGH                     credit covers PRICE while collecting
//   o_VEND_REQ                   held vend request (VEND_WAIT)
//   o_CHANGE_NICKEL              one nickel returned per high cycle (CHANGE)
//   o_COIN_REJECT                one-cycle pulse for a coin that was not credited
//   o_BUSY                       VEND_WAIT or CHANGE
module coin_credit_accumulator #(
    parameter int PRICE      = 75,
    parameter int MAX_CREDIT = 200,
    parameter int CREDIT_W   = 8
) (
    input  logic                i_CLK,
    input  logic                i_RESET,
    input  logic                i_NICKEL,
    input  logic                i_DIME,
    input  logic                i_QUARTER,
    input  logic                i_SELECT,
    input  logic                i_CANCEL,
    input  logic                i_VEND_DONE,
    output logic [CREDIT_W-1:0] o_CREDIT,
    output logic                o_ENOUGH,
    output logic                o_VEND_REQ,
    output logic                o_CHANGE_NICKEL,
    output logic                o_COIN_REJECT,
    output logic                o_BUSY
);
    localparam int W1 = CREDIT_W + 1;
    localparam logic [W1-1:0]       MAX_C    = W1'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] NICKEL_C = CREDIT_W'(5);

    typedef enum logic [1:0] {IDLE, COLLECT, VEND_WAIT, CHANGE} state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                reject_q, reject_d;
    logic                any_coin, multi_coin, open, accept;
    logic [W1-1:0]       coin_val, sum;

    always_comb begin
        any_coin   = i_NICKEL | i_DIME | i_QUARTER;
        multi_coin = (i_NICKEL & i_DIME) | (i_NICKEL & i_QUARTER) | (i_DIME & i_QUARTER);
        coin_val   = i_QUARTER ? W1'(25) : i_DIME ? W1'(10) : W1'(5);
        // one extra bit so an overflowing sum is caught before truncation
        sum        = {1'b0, credit_q} + coin_val;
        open       = (state_q == IDLE) || (state_q == COLLECT);
        accept     = any_coin && !multi_coin && open && !i_SELECT && !i_CANCEL && (sum <= MAX_C);
        reject_d   = any_coin && !accept;
        state_d    = state_q;
        credit_d   = credit_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = COLLECT;
                    credit_d = sum[CREDIT_W-1:0];
                end
            end
            COLLECT: begin
                if (i_CANCEL) begin
                    state_d = CHANGE;
                end else if (i_SELECT && credit_q >= PRICE_C) begin
                    state_d  = VEND_WAIT;
                    credit_d = credit_q - PRICE_C;
                end else if (accept) begin
                    credit_d = sum[CREDIT_W-1:0];
                end
            end
            VEND_WAIT: begin
                if (i_VEND_DONE) state_d = (credit_q != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                // last nickel leaves on the edge where credit reaches zero
                credit_d = (credit_q > NICKEL_C) ? credit_q - NICKEL_C : '0;
                state_d  = (credit_q > NICKEL_C) ? CHANGE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            state_q  <= IDLE;
            credit_q <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            reject_q <= reject_d;
        end
    end

    assign o_CREDIT        = credit_q;
    assign o_ENOUGH        = (state_q == COLLECT) && (credit_q >= PRICE_C);
    assign o_VEND_REQ      = (state_q == VEND_WAIT);
    assign o_CHANGE_NICKEL = (state_q == CHANGE);
    assign o_COIN_REJECT   = reject_q;
    assign o_BUSY          = (state_q == VEND_WAIT) || (state_q == CHANGE);
endmodule
